eth_tx_arb_n: RTL and testbench

- Parametrised N-input packet-atomic egress arbiter for the Ethernet transmit path.
- Generalises the fixed 4-input priority mux ahead of the ethout FIFO to NUM_PORTS inputs, with selectable fixed-priority or round-robin mode.
- Adds a settings-bus port-enable mask and max-length truncation: an oversize packet is cut, error-flagged and its remainder drained.
- Sits between the ZPU / framer / crossover sources and the egress FIFO.

---
 rtl/eth_tx_arb_n.sv | 171 +++++++++++++++++
 tb/tb_eth_tx_arb_n.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arb_n.sv
// rtl/eth_tx_arb_n.sv - N-input packet-atomic egress arbiter with port mask and length truncation
module eth_tx_arb_n #(
  parameter int NUM_PORTS  = 4,
  parameter int WIDTH      = 64,
  parameter int USER_WIDTH = 4,
  parameter int MODE       = 1,
  parameter int MAX_BEATS  = 1250,
  parameter int BASE       = 0,
  localparam int AW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic                            set_stb,
  input  logic [7:0]                      set_addr,
  input  logic [31:0]                     set_data,
  input  logic [NUM_PORTS*WIDTH-1:0]      i_tdata,
  input  logic [NUM_PORTS*USER_WIDTH-1:0] i_tuser,
  input  logic [NUM_PORTS-1:0]            i_tlast,
  input  logic [NUM_PORTS-1:0]            i_tvalid,
  output logic [NUM_PORTS-1:0]            i_tready,
  output logic [WIDTH-1:0]                o_tdata,
  output logic [USER_WIDTH-1:0]           o_tuser,
  output logic                            o_tlast,
  output logic                            o_tvalid,
  input  logic                            o_tready,
  output logic [AW-1:0]                   active_port,
  output logic                            busy,
  output logic [31:0]                     trunc_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_PORTS-1:0]  r_mask;
  logic [AW-1:0]         r_grant;
  logic [AW-1:0]         r_last_grant;
  logic [15:0]           r_beats;
  logic [31:0]           r_trunc;

  logic [NUM_PORTS-1:0]  w_cand;
  logic                  w_found;
  logic [AW-1:0]         w_pick;
  logic                  w_sel_valid;
  logic                  w_sel_last;
  logic [WIDTH-1:0]      w_sel_data;
  logic [USER_WIDTH-1:0] w_sel_user;
  logic                  w_pass;
  logic                  w_fire;
  logic                  w_at_limit;
  logic                  w_trunc_beat;
  logic                  w_unused_set_data;

  // Only the low NUM_PORTS bits of the settings word form the mask
  assign w_unused_set_data = ^set_data[31:NUM_PORTS];

  assign w_cand = i_tvalid & r_mask;

  // Choose the next grant: ports above the last grant first (round robin), then wrap from port 0
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && w_cand[j] && (MODE == 0 || j > int'(r_last_grant))) begin
        w_found = 1'b1;
        w_pick  = AW'(j);
      end
    end
    for (int j = 0; j < NUM_PORTS; j++) begin
      if (!w_found && w_cand[j]) begin
        w_found = 1'b1;
        w_pick  = AW'(j);
      end
    end
  end

  assign w_sel_valid  = i_tvalid[r_grant];
  assign w_sel_last   = i_tlast[r_grant];
  assign w_sel_data   = i_tdata[r_grant*WIDTH +: WIDTH];
  assign w_sel_user   = i_tuser[r_grant*USER_WIDTH +: USER_WIDTH];
  assign w_pass       = (r_state == S_PASS);
  assign w_fire       = w_pass && w_sel_valid && o_tready;
  assign w_at_limit   = (r_beats == 16'(MAX_BEATS - 1));
  assign w_trunc_beat = w_pass && !w_sel_last && w_at_limit;

  // Steer the granted port to the output; the truncating beat is forced to end the packet flagged as errored
  always_comb begin
    o_tvalid              = 1'b0;
    o_tdata               = w_sel_data;
    o_tuser               = w_sel_user;
    o_tuser[USER_WIDTH-1] = w_sel_user[USER_WIDTH-1] | w_trunc_beat;
    o_tlast               = w_sel_last | w_trunc_beat;
    i_tready              = '0;
    case (r_state)
      S_PASS: begin
        o_tvalid          = w_sel_valid;
        i_tready[r_grant] = o_tready;
      end
      S_DRAIN: begin
        i_tready[r_grant] = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Packet FSM: arbitrate in IDLE, forward in PASS, discard the oversize remainder in DRAIN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= AW'(NUM_PORTS - 1);
      r_beats      <= '0;
      r_trunc      <= '0;
    end else if (clear) begin
      r_state <= S_IDLE;
      r_beats <= '0;
      r_trunc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_beats      <= '0;
            r_state      <= S_PASS;
          end
        end
        S_PASS: begin
          if (w_fire) begin
            r_beats <= r_beats + 16'd1;
            if (w_sel_last) begin
              r_state <= S_IDLE;
            end else if (w_at_limit) begin
              r_state <= S_DRAIN;
              if (r_trunc != 32'hFFFF_FFFF) begin
                r_trunc <= r_trunc + 32'd1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (w_sel_valid && w_sel_last) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Enable mask register; sampled only by IDLE arbitration so in-flight packets are unaffected
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '1;
    end else if (set_stb && set_addr == 8'(BASE)) begin
      r_mask <= set_data[NUM_PORTS-1:0];
    end
  end

  assign active_port = r_grant;
  assign busy        = (r_state != S_IDLE);
  assign trunc_count = r_trunc;

endmodule

// File: tb/tb_eth_tx_arb_n.sv
// tb/tb_eth_tx_arb_n.sv - scoreboard bench for eth_tx_arb_n with per-port packet reference model
module tb_eth_tx_arb_n;
  localparam int NP   = 4;
  localparam int W    = 32;
  localparam int UW   = 4;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             set_stb;
  logic [7:0]       set_addr;
  logic [31:0]      set_data;
  logic [NP*W-1:0]  i_tdata;
  logic [NP*UW-1:0] i_tuser;
  logic [NP-1:0]    i_tlast;
  logic [NP-1:0]    i_tvalid;
  logic [NP-1:0]    i_tready;
  logic [W-1:0]     o_tdata;
  logic [UW-1:0]    o_tuser;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;
  logic [1:0]       active_port;
  logic             busy;
  logic [31:0]      trunc_count;

  logic [NP*W-1:0]  fp_tdata;
  logic [NP*UW-1:0] fp_tuser;
  logic [NP-1:0]    fp_tlast;
  logic [NP-1:0]    fp_tvalid;
  logic [NP-1:0]    fp_i_tready;
  logic [W-1:0]     fp_o_tdata;
  logic [UW-1:0]    fp_o_tuser;
  logic             fp_o_tlast;
  logic             fp_o_tvalid;
  logic             fp_o_tready;
  logic [1:0]       fp_active;
  logic             fp_busy;
  logic [31:0]      fp_trunc;

  eth_tx_arb_n #(.NUM_PORTS(NP), .WIDTH(W), .USER_WIDTH(UW), .MODE(1), .MAX_BEATS(MAXB), .BASE(0)) dut (
    .clk(clk), .reset_n(rst_n), .clear(clear), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(i_tdata), .i_tuser(i_tuser), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .active_port(active_port), .busy(busy), .trunc_count(trunc_count)
  );

  eth_tx_arb_n #(.NUM_PORTS(NP), .WIDTH(W), .USER_WIDTH(UW), .MODE(0), .MAX_BEATS(MAXB), .BASE(0)) dut_fp (
    .clk(clk), .reset_n(rst_n), .clear(clear), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .i_tdata(fp_tdata), .i_tuser(fp_tuser), .i_tlast(fp_tlast), .i_tvalid(fp_tvalid), .i_tready(fp_i_tready),
    .o_tdata(fp_o_tdata), .o_tuser(fp_o_tuser), .o_tlast(fp_o_tlast), .o_tvalid(fp_o_tvalid), .o_tready(fp_o_tready),
    .active_port(fp_active), .busy(fp_busy), .trunc_count(fp_trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src_q [NP][$];
  beat_t exp_q [NP][$];
  int    exp_order [$];
  bit    hold [NP];
  bit    seen [NP];
  int    valid_pct = 100;
  int    ready_pct = 100;
  int    n_checks = 0;
  int    n_pass = 0;
  int    model_trunc = 0;
  int    seq_no = 0;
  int    cyc = 0;
  int    last_cyc = 0;
  int    cur_port = 0;
  bit    have_last = 1'b0;
  bit    gap_chk = 1'b0;
  bit    in_pkt = 1'b0;
  bit    watch_p1 = 1'b0;
  bit    p1_bad = 1'b0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the expected output of a packet follows directly from its length and MAX_BEATS
  task automatic gen_packet(input int port, input int len, input bit push);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.d = {port[1:0], seq_no[13:0], 16'($urandom)};
      b.u = 4'($urandom);
      b.l = (i == len - 1);
      src_q[port].push_back(b);
      if (push && i < MAXB) begin
        if (len > MAXB && i == MAXB - 1) begin
          b.l = 1'b1;
          b.u[UW-1] = 1'b1;
        end
        exp_q[port].push_back(b);
      end
    end
    if (push && len > MAXB) model_trunc++;
    seq_no++;
  endtask

  function automatic bit all_empty(input int skip);
    for (int k = 0; k < NP; k++) begin
      if (exp_q[k].size() != 0) return 1'b0;
      if (k != skip && src_q[k].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget, input int skip);
    int n = 0;
    while (!all_empty(skip) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(name, 64'(all_empty(skip)), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic set_mask(input logic [31:0] v);
    @(posedge clk); #1;
    set_stb = 1'b1; set_addr = 8'd0; set_data = v;
    @(posedge clk); #1;
    set_stb = 1'b0;
  endtask

  task automatic clear_seen();
    for (int k = 0; k < NP; k++) seen[k] = 1'b0;
  endtask

  // Source driver: each port presents its queued beats, holding valid until accepted
  initial begin : driver
    bit fired [NP];
    i_tvalid = '0; i_tdata = '0; i_tuser = '0; i_tlast = '0; o_tready = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NP; k++) fired[k] = i_tvalid[k] && i_tready[k];
      @(posedge clk);
      #1;
      for (int k = 0; k < NP; k++) begin
        if (fired[k] && src_q[k].size() > 0) begin
          void'(src_q[k].pop_front());
          hold[k] = 1'b0;
        end
        if (src_q[k].size() == 0) begin
          i_tvalid[k] = 1'b0;
          hold[k] = 1'b0;
        end else begin
          if (!hold[k]) hold[k] = (int'($urandom_range(99)) < valid_pct);
          i_tvalid[k] = hold[k];
          i_tdata[k*W +: W]   = src_q[k][0].d;
          i_tuser[k*UW +: UW] = src_q[k][0].u;
          i_tlast[k]          = src_q[k][0].l;
        end
      end
      o_tready = (int'($urandom_range(99)) < ready_pct);
    end
  end

  // Output monitor: pops the expected beat of the port encoded in the data and compares
  initial begin : monitor
    int p;
    beat_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (watch_p1 && i_tready[1]) p1_bad = 1'b1;
      if (rst_n && o_tvalid && o_tready) begin
        p = int'(o_tdata[W-1 -: 2]);
        seen[p] = 1'b1;
        if (!in_pkt) begin
          if (exp_order.size() > 0) check_eq("grant_order", 64'(p), 64'(exp_order.pop_front()));
          if (gap_chk && have_last) check_eq("idle_gap", 64'(cyc - last_cyc), 64'd2);
          in_pkt = 1'b1;
          cur_port = p;
        end else begin
          check_eq("no_interleave", 64'(p), 64'(cur_port));
        end
        check_eq("beat_expected", 64'(exp_q[p].size() > 0), 64'd1);
        if (exp_q[p].size() > 0) begin
          e = exp_q[p].pop_front();
          check_eq("beat_content", 64'({o_tdata, o_tuser, o_tlast}), 64'(e));
        end
        if (o_tlast) begin
          in_pkt = 1'b0;
          last_cyc = cyc;
          have_last = 1'b1;
        end
      end
    end
  end

  initial begin : sequencer
    int n;
    bit found;
    rst_n = 1'b0; clear = 1'b0; set_stb = 1'b0; set_addr = '0; set_data = '0;
    fp_tdata = '0; fp_tuser = '0; fp_tlast = '1; fp_tvalid = '0; fp_o_tready = 1'b1;
    for (int k = 0; k < NP; k++) fp_tdata[k*W +: W] = 32'hA000_0000 + 32'(k);
    repeat (3) @(negedge clk);
    check_eq("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check_eq("rst_i_tready", 64'(i_tready), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_active_port", 64'(active_port), 64'd0);
    check_eq("rst_trunc_count", 64'(trunc_count), 64'd0);

    // Fixed priority: port 1 wins over port 3 while it stays valid
    fp_tvalid = 4'b1010;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (fp_o_tvalid) check_eq("fp_prio_port1", 64'(fp_o_tdata), 64'h0A000_0001);
    end
    found = 1'b0; n = 0;
    while (!found && n < 10) begin
      @(negedge clk);
      found = fp_o_tvalid && fp_o_tready;
      n++;
    end
    check_eq("fp_fire_seen", 64'(found), 64'd1);
    @(posedge clk); #1;
    fp_tvalid[1] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!fp_o_tvalid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_eq("fp_port3_data", 64'(fp_o_tdata), 64'h0A000_0003);
    check_eq("fp_port3_ready", 64'(fp_i_tready), 64'b1000);
    @(posedge clk); #1;
    fp_tvalid = '0;

    // Round robin with all ports continuously valid, 3-beat packets
    valid_pct = 100; ready_pct = 100; gap_chk = 1'b1; have_last = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NP; k++) begin
        gen_packet(k, 3, 1'b1);
        exp_order.push_back(k);
      end
    end
    wait_idle("rr_drain", 200, -1);
    gap_chk = 1'b0;
    check_eq("rr_order_consumed", 64'(exp_order.size()), 64'd0);

    // Truncation of a 7-beat packet, then an exactly-MAX_BEATS packet
    gen_packet(0, 7, 1'b1);
    gen_packet(0, 4, 1'b1);
    wait_idle("trunc_drain", 200, -1);
    check_eq("trunc_count_one", 64'(trunc_count), 64'd1);
    check_eq("trunc_count_model", 64'(trunc_count), 64'(model_trunc));

    // Mask write while port 1 is mid-packet
    clear_seen();
    gen_packet(1, 4, 1'b1);
    n = 0;
    while (!seen[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("p1_started", 64'(seen[1]), 64'd1);
    set_mask(32'h5);
    for (int r = 0; r < 2; r++) begin
      gen_packet(0, 3, 1'b1);
      gen_packet(2, 2, 1'b1);
    end
    gen_packet(1, 3, 1'b0);
    n = 0;
    while (exp_q[1].size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    p1_bad = 1'b0;
    watch_p1 = 1'b1;
    wait_idle("mask_drain", 300, 1);
    check_eq("p1_blocked_left", 64'(src_q[1].size()), 64'd3);
    check_eq("p1_never_ready", 64'(p1_bad), 64'd0);
    watch_p1 = 1'b0;
    src_q[1].delete();
    hold[1] = 1'b0;
    set_mask(32'hF);

    // Random traffic with backpressure and valid gaps
    valid_pct = 60; ready_pct = 70;
    for (int i = 0; i < 1000; i++) gen_packet(int'($urandom_range(NP - 1)), int'($urandom_range(6, 1)), 1'b1);
    wait_idle("random_drain", 40000, -1);
    check_eq("trunc_count_random", 64'(trunc_count), 64'(model_trunc));

    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    model_trunc = 0;
    check_eq("clear_trunc", 64'(trunc_count), 64'(model_trunc));

    // Asynchronous reset in the middle of a packet
    valid_pct = 100; ready_pct = 100;
    gen_packet(3, 6, 1'b1);
    wait_idle("pre_reset_drain", 200, -1);
    check_eq("pre_reset_trunc", 64'(trunc_count), 64'(model_trunc));
    clear_seen();
    gen_packet(2, 4, 1'b1);
    n = 0;
    while (!seen[2] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("p2_started", 64'(seen[2]), 64'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("async_o_tvalid", 64'(o_tvalid), 64'd0);
    check_eq("async_i_tready", 64'(i_tready), 64'd0);
    check_eq("async_busy", 64'(busy), 64'd0);
    check_eq("async_active_port", 64'(active_port), 64'd0);
    check_eq("async_trunc_count", 64'(trunc_count), 64'd0);
    for (int k = 0; k < NP; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      hold[k] = 1'b0;
    end
    exp_order.delete();
    in_pkt = 1'b0;
    model_trunc = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_order.push_back(0);
    for (int k = NP - 1; k >= 0; k--) gen_packet(k, 2, 1'b1);
    wait_idle("post_reset_drain", 200, -1);
    check_eq("post_reset_order", 64'(exp_order.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
